// File: rtl/padder_pkg.sv
// Shared constants for the SHA3-512 input padder (576-bit rate, 64-bit words).
package padder_pkg;

  localparam int RATE_BITS = 576;
  localparam int WORD_BITS = 64;
  localparam int NUM_WORDS = RATE_BITS / WORD_BITS;  // 9 words per block

  // Keccak multi-rate padding markers: first pad byte and last byte of block.
  localparam logic [7:0] PAD_START = 8'h01;
  localparam logic [7:0] PAD_END   = 8'h80;

endpackage : padder_pkg

// File: rtl/padder_pad_word.sv
// Builds the final message word: keeps the first byte_num bytes of in
// (most significant first), appends the 0x01 marker and zero-fills the rest.
module padder_pad_word
  import padder_pkg::*;
(
  input  logic [WORD_BITS-1:0] in,
  input  logic [2:0]           byte_num,
  output logic [WORD_BITS-1:0] word
);

  // Byte i sits at bits [63-8i -: 8]; bytes below byte_num are message,
  // byte byte_num is the marker, everything after stays zero.
  always_comb begin
    word = '0;
    for (int i = 0; i < 8; i++) begin
      if (3'(i) < byte_num) begin
        word[63-8*i -: 8] = in[63-8*i -: 8];
      end else if (3'(i) == byte_num) begin
        word[63-8*i -: 8] = PAD_START;
      end
    end
  end

endmodule : padder_pad_word

// File: rtl/padder.sv
// SHA3-512 input stage: packs 64-bit message words into 576-bit blocks and
// applies Keccak multi-rate padding (0x01 ... 0x80).
//
// Handshakes:
//   input  side: a word is consumed on a rising edge when in_ready=1 and
//                buffer_full=0 (and the message is not yet in padding mode).
//   output side: out_ready=1 means out holds a complete block; it stays
//                stable until the consumer pulses f_ack, which empties the
//                buffer on that edge.
module padder
  import padder_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic [WORD_BITS-1:0] in,
  input  logic                 in_ready,
  input  logic                 is_last,
  input  logic [2:0]           byte_num,
  output logic                 buffer_full,
  output logic [RATE_BITS-1:0] out,
  output logic                 out_ready,
  input  logic                 f_ack
);

  // Thermometer word counter: bit k set means k+1 words are in the buffer.
  logic [NUM_WORDS-1:0] cnt;
  // pad_mode: the last message word has been taken, the rest is padding.
  // done: the padded final block is complete; the padder is idle until reset.
  logic                 pad_mode;
  logic                 done;

  logic                 accept;
  logic                 update;
  logic [WORD_BITS-1:0] padded;
  logic [WORD_BITS-1:0] w;

  assign buffer_full = cnt[NUM_WORDS-1];
  assign out_ready   = buffer_full;

  assign accept = ~pad_mode & in_ready & ~buffer_full;
  assign update = (accept | (pad_mode & ~buffer_full)) & ~done;

  padder_pad_word u_pad_word (
    .in       (in),
    .byte_num (byte_num),
    .word     (padded)
  );

  // Choose the word shifted in this cycle; padding words landing in the
  // ninth slot also carry the closing 0x80 bit.
  always_comb begin
    w = in;
    if (pad_mode) begin
      w = '0;
    end else if (is_last) begin
      w = padded;
    end
    if ((pad_mode | is_last) & cnt[NUM_WORDS-2]) begin
      w[7:0] = w[7:0] | PAD_END;
    end
  end

  // Block buffer, word counter and padding flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      out      <= '0;
      cnt      <= '0;
      pad_mode <= 1'b0;
      done     <= 1'b0;
    end else begin
      if (update) begin
        out <= {out[RATE_BITS-WORD_BITS-1:0], w};
      end
      if (f_ack | update) begin
        cnt <= {cnt[NUM_WORDS-2:0], 1'b1} & {NUM_WORDS{~f_ack}};
      end
      if (accept & is_last) begin
        pad_mode <= 1'b1;
      end
      if (pad_mode & buffer_full) begin
        done <= 1'b1;
      end
    end
  end

endmodule : padder

// File: tb/tb_padder.sv
// Directed bench for padder: a table of single-block messages plus
// hand-written sequences for empty message, two-block stall and mid-block reset.
module tb_padder;

  logic         clk = 1'b0;
  logic         reset;
  logic [63:0]  in;
  logic         in_ready;
  logic         is_last;
  logic [2:0]   byte_num;
  logic         buffer_full;
  logic [575:0] out;
  logic         out_ready;
  logic         f_ack;

  int n_cmp = 0;
  int n_err = 0;

  localparam logic [63:0] WORD = 64'h1234567890ABCDEF;

  typedef struct {
    int          n_words;   // plain words before the last word
    logic [63:0] data;
    logic [2:0]  bn;
    logic [63:0] exp_pad;   // hand-computed last word, before any 0x80
  } vec_t;

  vec_t vecs[10];

  padder dut (
    .clk         (clk),
    .reset       (reset),
    .in          (in),
    .in_ready    (in_ready),
    .is_last     (is_last),
    .byte_num    (byte_num),
    .buffer_full (buffer_full),
    .out         (out),
    .out_ready   (out_ready),
    .f_ack       (f_ack)
  );

  // clock
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: run did not finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [575:0] act, input logic [575:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Called at a negedge; applies inputs for the next rising edge and
  // returns at the following negedge, where outputs are stable.
  task automatic drive(input logic [63:0] d, input logic rdy, input logic last,
                       input logic [2:0] bn, input logic ack);
    in       = d;
    in_ready = rdy;
    is_last  = last;
    byte_num = bn;
    f_ack    = ack;
    @(negedge clk);
    in_ready = 1'b0;
    is_last  = 1'b0;
    f_ack    = 1'b0;
  endtask

  task automatic idle();
    drive(64'h0, 1'b0, 1'b0, 3'd0, 1'b0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle();
    idle();
    reset = 1'b0;
  endtask

  task automatic wait_ready(input string name);
    int i;
    for (i = 0; i < 20 && !out_ready; i++) idle();
    if (!out_ready) check({name, "_ready_timeout"}, 576'(out_ready), 576'(1));
  endtask

  // Expected block: message words, padded word, zeros, 0x80 in the final byte.
  function automatic logic [575:0] exp_block(input int n, input logic [63:0] d,
                                             input logic [63:0] pad);
    logic [63:0]  s[9];
    logic [575:0] e;
    for (int i = 0; i < 9; i++) s[i] = 64'h0;
    for (int i = 0; i < n; i++) s[i] = d;
    s[n] = pad;
    s[8][7:0] = s[8][7:0] | 8'h80;
    e = '0;
    for (int i = 0; i < 9; i++) e = {e[511:0], s[i]};
    return e;
  endfunction

  task automatic run_msg(input string name, input int n, input logic [63:0] d,
                         input logic [2:0] bn, input logic [63:0] pad);
    for (int i = 0; i < n; i++) drive(d, 1'b1, 1'b0, 3'd0, 1'b0);
    drive(d, 1'b1, 1'b1, bn, 1'b0);
    wait_ready(name);
    check({name, "_out"}, out, exp_block(n, d, pad));
    check({name, "_out_ready"}, 576'(out_ready), 576'(1));
    drive(64'h0, 1'b0, 1'b0, 3'd0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      idle();
      check({name, "_idle_after_ack"}, 576'(out_ready), 576'(0));
    end
  endtask

  initial begin
    logic [575:0] full9;
    in = '0; in_ready = 0; is_last = 0; byte_num = 0; f_ack = 0; reset = 1;

    vecs[0] = '{8, 64'h1234567890ABCDEF, 3'd7, 64'h1234567890ABCD01};
    vecs[1] = '{8, 64'h1234567890ABCDEF, 3'd0, 64'h0100000000000000};
    vecs[2] = '{8, 64'h1234567890ABCDEF, 3'd6, 64'h1234567890AB0100};
    vecs[3] = '{8, 64'h1234567890ABCDEF, 3'd1, 64'h1201000000000000};
    vecs[4] = '{3, 64'h1234567890ABCDEF, 3'd3, 64'h1234560100000000};
    vecs[5] = '{0, 64'hA5A5A5A5A5A5A5A5, 3'd4, 64'hA5A5A5A501000000};
    vecs[6] = '{5, 64'hFEDCBA9876543210, 3'd5, 64'hFEDCBA9876010000};
    vecs[7] = '{7, 64'h0011223344556677, 3'd2, 64'h0011010000000000};
    vecs[8] = '{1, 64'hFFFFFFFFFFFFFFFF, 3'd7, 64'hFFFFFFFFFFFFFF01};
    vecs[9] = '{6, 64'h8000000000000001, 3'd0, 64'h0100000000000000};

    @(negedge clk);
    do_reset();
    check("reset_out", out, 576'h0);
    check("reset_full", 576'(buffer_full), 576'(0));
    check("reset_out_ready", 576'(out_ready), 576'(0));

    // table-driven single-block messages (first entry: no idle after reset)
    for (int v = 0; v < 10; v++) begin
      do_reset();
      run_msg($sformatf("vec%0d", v), vecs[v].n_words, vecs[v].data,
              vecs[v].bn, vecs[v].exp_pad);
    end

    // empty message, with a second is_last pulse that must be ignored
    do_reset();
    for (int i = 0; i < 7; i++) idle();
    check("empty_pre_full", 576'(buffer_full), 576'(0));
    drive(64'h0, 1'b1, 1'b1, 3'd0, 1'b0);
    drive(64'h0, 1'b1, 1'b1, 3'd0, 1'b0);
    wait_ready("empty");
    check("empty_out", out, {8'h01, 560'h0, 8'h80});
    check("empty_out_ready", 576'(out_ready), 576'(1));
    drive(64'h0, 1'b0, 1'b0, 3'd0, 1'b1);
    for (int i = 0; i < 6; i++) begin
      check("empty_after_ack", 576'(buffer_full), 576'(0));
      idle();
    end

    // two-block message with a stall while full
    do_reset();
    for (int i = 0; i < 9; i++) drive(WORD, 1'b1, 1'b0, 3'd0, 1'b0);
    full9 = {9{WORD}};
    check("stall_out_ready", 576'(out_ready), 576'(1));
    check("stall_out", out, full9);
    for (int i = 0; i < 3; i++) begin
      drive(64'h999, 1'b1, 1'b0, 3'd0, 1'b0);
      check("stall_full_held", 576'(buffer_full), 576'(1));
      check("stall_out_held", out, full9);
    end
    drive(WORD, 1'b0, 1'b0, 3'd0, 1'b1);
    check("stall_after_ack", 576'(out_ready), 576'(0));
    for (int i = 0; i < 8; i++) drive(WORD, 1'b1, 1'b0, 3'd0, 1'b0);
    drive(WORD, 1'b1, 1'b1, 3'd6, 1'b0);
    wait_ready("block2");
    check("block2_out", out, {{8{WORD}}, 64'h1234567890AB0180});
    drive(64'h0, 1'b0, 1'b0, 3'd0, 1'b1);
    for (int i = 0; i < 10; i++) begin
      check("block2_done_idle", 576'(out_ready), 576'(0));
      idle();
    end
    // late pulses after done are ignored
    drive(WORD, 1'b1, 1'b1, 3'd0, 1'b0);
    for (int i = 0; i < 10; i++) idle();
    check("done_ignores_input", 576'(out_ready), 576'(0));

    // reset in the middle of a block
    do_reset();
    for (int i = 0; i < 3; i++) drive(WORD, 1'b1, 1'b0, 3'd0, 1'b0);
    do_reset();
    check("midreset_out", out, 576'h0);
    check("midreset_full", 576'(buffer_full), 576'(0));
    run_msg("after_midreset", 2, 64'hCAFEBABEDEADBEEF, 3'd3, 64'hCAFEBA0100000000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_padder
